// File: rtl/gate_check_pkg.sv
// Shared types and helpers for the gate response checker.
// Tables are carried at the widest supported size so one helper serves every instance.
package gate_check_pkg;

    localparam int MAX_N_IN = 6;
    localparam int MAX_ROWS = 1 << MAX_N_IN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of truth-table rows for a gate with n_in inputs.
    function automatic int rows(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic logic expected_out(input logic [MAX_ROWS-1:0] tbl,
                                          input logic [MAX_N_IN-1:0] vec);
        return tbl[vec];
    endfunction

endpackage

// File: rtl/coverage_tracker.sv
// Bitmap of input vectors accepted during the current run.
// all_covered_next looks ahead by one beat so the FSM can finish on the covering handshake.
module coverage_tracker
    import gate_check_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int ROWS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            hit,
    input  logic [N_IN-1:0] idx,
    output logic [ROWS-1:0] bitmap,
    output logic            all_covered_next
);

    logic [ROWS-1:0] hit_mask;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        hit_mask = '0;
        if (hit) begin
            hit_mask[idx] = 1'b1;
        end
    end

    assign all_covered_next = &(bitmap | hit_mask);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap <= '0;
        end else if (clear) begin
            bitmap <= '0;
        end else begin
            bitmap <= bitmap | hit_mask;
        end
    end

endmodule

// File: rtl/gate_response_checker.sv
// Compares a stream of (input vector, observed output) samples against a truth table,
// counting mismatches, capturing the first failure and finishing once every row is seen.
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter int                     N_IN        = 2,
    parameter logic [(1<<N_IN)-1:0]   TRUTH_TABLE = 4'b1000,
    parameter int                     CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [N_IN-1:0]       s_in,
    input  logic                  s_y,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      err_count,
    output logic                  first_err_valid,
    output logic [N_IN-1:0]       first_err_vec,
    output logic                  first_err_y,
    output logic [(1<<N_IN)-1:0]  coverage
);

    localparam int ROWS = rows(N_IN);
    localparam logic [MAX_ROWS-1:0] TABLE_EXT = MAX_ROWS'(TRUTH_TABLE);

    state_t state;
    logic   handshake;
    logic   mismatch;
    logic   begin_run;
    logic   all_covered_next;

    // Decoded from the state register only, so there is no input-to-ready path.
    assign s_ready   = (state == RUN);
    assign handshake = s_valid && s_ready;
    assign mismatch  = handshake && (s_y != expected_out(TABLE_EXT, MAX_N_IN'(s_in)));
    assign begin_run = start && (state != RUN);

    coverage_tracker #(
        .N_IN (N_IN),
        .ROWS (ROWS)
    ) u_coverage (
        .clk              (clk),
        .rst              (rst),
        .clear            (begin_run),
        .hit              (handshake),
        .idx              (s_in),
        .bitmap           (coverage),
        .all_covered_next (all_covered_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            first_err_y     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= RUN;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                        first_err_y     <= 1'b0;
                    end
                end
                RUN: begin
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= s_in;
                            first_err_y     <= s_y;
                        end
                    end
                    // Pass must account for a mismatch on the covering beat itself.
                    if (handshake && all_covered_next) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench: default AND checker, a 2-bit-counter AND checker and an XOR3 checker.
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    // Default instance: 2-input AND, 16-bit counter.
    logic        start_a = 0, valid_a = 0, y_a = 0;
    logic [1:0]  in_a = '0;
    logic        ready_a, busy_a, done_a, pass_a, fevv_a, fey_a;
    logic [15:0] err_a;
    logic [1:0]  fev_a;
    logic [3:0]  cov_a;

    // AND with a 2-bit counter, for saturation.
    logic        start_b = 0, valid_b = 0, y_b = 0;
    logic [1:0]  in_b = '0;
    logic        ready_b, busy_b, done_b, pass_b, fevv_b, fey_b;
    logic [1:0]  err_b;
    logic [1:0]  fev_b;
    logic [3:0]  cov_b;

    // 3-input XOR.
    logic        start_c = 0, valid_c = 0, y_c = 0;
    logic [2:0]  in_c = '0;
    logic        ready_c, busy_c, done_c, pass_c, fevv_c, fey_c;
    logic [15:0] err_c;
    logic [2:0]  fev_c;
    logic [7:0]  cov_c;

    gate_response_checker u_a (
        .clk(clk), .rst(rst), .start(start_a), .s_valid(valid_a), .s_ready(ready_a),
        .s_in(in_a), .s_y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_valid(fevv_a), .first_err_vec(fev_a),
        .first_err_y(fey_a), .coverage(cov_a)
    );

    gate_response_checker #(.CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .s_valid(valid_b), .s_ready(ready_b),
        .s_in(in_b), .s_y(y_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_valid(fevv_b), .first_err_vec(fev_b),
        .first_err_y(fey_b), .coverage(cov_b)
    );

    gate_response_checker #(.N_IN(3), .TRUTH_TABLE(8'b1001_0110)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .s_valid(valid_c), .s_ready(ready_c),
        .s_in(in_c), .s_y(y_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_err_valid(fevv_c), .first_err_vec(fev_c),
        .first_err_y(fey_c), .coverage(cov_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Outputs are examined 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
    endtask

    task automatic send_a(input logic [1:0] v, input logic y);
        valid_a = 1'b1; in_a = v; y_a = y; tick(); valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] v, input logic y);
        valid_b = 1'b1; in_b = v; y_b = y; tick(); valid_b = 1'b0;
    endtask

    task automatic send_c(input logic [2:0] v, input logic y);
        valid_c = 1'b1; in_c = v; y_c = y; tick(); valid_c = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_ready", 64'(ready_a), 64'h0);
        check("rst_busy",  64'(busy_a),  64'h0);
        check("rst_done",  64'(done_a),  64'h0);
        check("rst_pass",  64'(pass_a),  64'h0);
        check("rst_err",   64'(err_a),   64'h0);
        check("rst_cov",   64'(cov_a),   64'h0);
        check("rst_fevv",  64'(fevv_a),  64'h0);
        check("rst_cov_c", 64'(cov_c),   64'h0);
        rst = 1'b0;
        tick();
        check("idle_ready", 64'(ready_a), 64'h0);

        // Clean AND run
        pulse_a();
        check("t1_ready", 64'(ready_a), 64'h1);
        check("t1_busy",  64'(busy_a),  64'h1);
        send_a(2'b00, 1'b0);
        send_a(2'b01, 1'b0);
        send_a(2'b10, 1'b0);
        check("t1_cov3",  64'(cov_a),  64'h7);
        check("t1_done3", 64'(done_a), 64'h0);
        send_a(2'b11, 1'b1);
        check("t1_done",  64'(done_a),  64'h1);
        check("t1_pass",  64'(pass_a),  64'h1);
        check("t1_err",   64'(err_a),   64'h0);
        check("t1_cov",   64'(cov_a),   64'hF);
        check("t1_ready_after", 64'(ready_a), 64'h0);
        check("t1_busy_after",  64'(busy_a),  64'h0);
        valid_a = 1'b1; in_a = 2'b00; y_a = 1'b1;
        tick(); tick();
        valid_a = 1'b0;
        check("t1_no_accept_err", 64'(err_a),  64'h0);
        check("t1_done_held",     64'(done_a), 64'h1);

        // One wrong beat
        pulse_a();
        check("t2_done_clr", 64'(done_a),  64'h0);
        check("t2_cov_clr",  64'(cov_a),   64'h0);
        check("t2_ready",    64'(ready_a), 64'h1);
        send_a(2'b00, 1'b0);
        send_a(2'b01, 1'b0);
        send_a(2'b10, 1'b1);
        check("t2_err",  64'(err_a),  64'h1);
        check("t2_fevv", 64'(fevv_a), 64'h1);
        check("t2_fev",  64'(fev_a),  64'h2);
        check("t2_fey",  64'(fey_a),  64'h1);
        send_a(2'b11, 1'b1);
        check("t2_done",  64'(done_a), 64'h1);
        check("t2_pass",  64'(pass_a), 64'h0);
        check("t2_err_f", 64'(err_a),  64'h1);

        // Duplicates and stalls
        pulse_a();
        send_a(2'b00, 1'b0);
        check("t3_cov_a", 64'(cov_a), 64'h1);
        tick();
        send_a(2'b00, 1'b0);
        tick();
        send_a(2'b00, 1'b0);
        check("t3_cov_dup", 64'(cov_a),  64'h1);
        check("t3_notdone", 64'(done_a), 64'h0);
        send_a(2'b01, 1'b0);
        check("t3_cov_b", 64'(cov_a), 64'h3);
        send_a(2'b10, 1'b0);
        check("t3_cov_c",    64'(cov_a),  64'h7);
        check("t3_notdone2", 64'(done_a), 64'h0);
        send_a(2'b11, 1'b1);
        check("t3_cov_d", 64'(cov_a),  64'hF);
        check("t3_done",  64'(done_a), 64'h1);
        check("t3_err",   64'(err_a),  64'h0);
        check("t3_pass",  64'(pass_a), 64'h1);

        // Counter saturation on a 2-bit counter
        start_b = 1'b1; tick(); start_b = 1'b0;
        send_b(2'b00, 1'b1);
        send_b(2'b00, 1'b1);
        send_b(2'b00, 1'b1);
        check("t4_err3", 64'(err_b), 64'h3);
        send_b(2'b00, 1'b1);
        send_b(2'b00, 1'b1);
        check("t4_err_sat", 64'(err_b), 64'h3);
        check("t4_fev",     64'(fev_b), 64'h0);
        check("t4_fey",     64'(fey_b), 64'h1);
        send_b(2'b01, 1'b0);
        send_b(2'b10, 1'b0);
        send_b(2'b11, 1'b1);
        check("t4_done",  64'(done_b), 64'h1);
        check("t4_pass",  64'(pass_b), 64'h0);
        check("t4_err_f", 64'(err_b),  64'h3);

        // Reset mid-run, with a simultaneous start and handshake
        pulse_a();
        send_a(2'b00, 1'b0);
        send_a(2'b01, 1'b0);
        check("t5_cov_pre", 64'(cov_a), 64'h3);
        rst = 1'b1; start_a = 1'b1; valid_a = 1'b1; in_a = 2'b10; y_a = 1'b1;
        tick();
        rst = 1'b0; start_a = 1'b0; valid_a = 1'b0;
        check("t5_ready", 64'(ready_a), 64'h0);
        check("t5_busy",  64'(busy_a),  64'h0);
        check("t5_done",  64'(done_a),  64'h0);
        check("t5_pass",  64'(pass_a),  64'h0);
        check("t5_err",   64'(err_a),   64'h0);
        check("t5_cov",   64'(cov_a),   64'h0);
        check("t5_fevv",  64'(fevv_a),  64'h0);
        check("t5_err_b", 64'(err_b),   64'h0);
        tick();
        check("t5_idle_cov", 64'(cov_a), 64'h0);
        pulse_a();
        check("t5_run_ready", 64'(ready_a), 64'h1);
        check("t5_run_cov",   64'(cov_a),   64'h0);
        send_a(2'b00, 1'b0);
        send_a(2'b01, 1'b0);
        send_a(2'b10, 1'b0);
        check("t5_cov3", 64'(cov_a),  64'h7);
        check("t5_nd",   64'(done_a), 64'h0);
        send_a(2'b11, 1'b1);
        check("t5_done2", 64'(done_a), 64'h1);
        check("t5_pass2", 64'(pass_a), 64'h1);
        check("t5_cov4",  64'(cov_a),  64'hF);

        // XOR3 in reverse order, start pulsed mid-run
        start_c = 1'b1; tick(); start_c = 1'b0;
        check("t6_ready", 64'(ready_c), 64'h1);
        for (int v = 7; v >= 0; v--) begin
            start_c = (v == 3);
            send_c(3'(v), ^3'(v));
            start_c = 1'b0;
            if (v == 1) begin
                check("t6_cov7", 64'(cov_c),  64'hFE);
                check("t6_nd",   64'(done_c), 64'h0);
                check("t6_err7", 64'(err_c),  64'h0);
            end
        end
        check("t6_done", 64'(done_c), 64'h1);
        check("t6_pass", 64'(pass_c), 64'h1);
        check("t6_cov",  64'(cov_c),  64'hFF);
        check("t6_err",  64'(err_c),  64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
